pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload bits per transfer.
REQ-002 SHALL have parameter ZERO_ON_FLUSH, default 1: 1 = flush clears the payload registers, 0 = payload registers keep their stale value.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port in_ready  output  1  stage accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port out_data  output  WIDTH  head payload.
REQ-012 SHALL have port count  output  2  entries held (0..2).

Function
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 SHALL hold at most two entries: main register (head) and skid register.
REQ-015 SHALL use FSM states EMPTY (count 0), BUSY (count 1, main valid) and FULL (count 2, main and skid valid).
REQ-016 SHALL drive out_valid = (state != EMPTY), out_data = main, in_ready = (state != FULL), count = state occupancy; all three are derived from registered state only, with no combinational path from in_valid or out_ready.
REQ-017 SHALL, in EMPTY, on in_fire load main <= in_data and go to BUSY; otherwise stay in EMPTY.
REQ-018 SHALL, in BUSY, apply these transitions: in_fire & out_fire -> main <= in_data, stay BUSY; in_fire & !out_fire -> skid <= in_data, go FULL; !in_fire & out_fire -> go EMPTY; neither -> hold.
REQ-019 SHALL, in FULL, on out_fire load main <= skid and go BUSY; otherwise hold both registers.
REQ-020 SHALL provide 1-cycle latency: data accepted at edge N is visible on out_data after edge N.
REQ-021 SHALL sustain 1 transfer per cycle while out_ready is held high.
REQ-022 SHALL never drop or duplicate an entry, and SHALL preserve FIFO order through the skid register.
REQ-023 SHALL give flush priority over in_fire and out_fire: next state EMPTY, any in_fire in the same cycle discarded, and main/skid cleared to 0 when ZERO_ON_FLUSH=1.
REQ-024 SHALL hold main, out_data and count unchanged while out_valid=1 and out_ready=0, with out_data stable.

Reset
REQ-025 SHALL, while reset=0, asynchronously force state EMPTY, main=0, skid=0, out_valid=0, count=0 and in_ready=0.
REQ-026 SHALL drive in_ready=1 from the first rising edge after reset deasserts; reset asserted mid-transfer SHALL discard all entries.

Structure
REQ-027 SHALL place the FSM state encoding (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) and the default WIDTH in the shared pipeline package, alongside per-stage payload width constants (IF/ID, ID/EX, EX/MEM, MEM/WB).
REQ-028 SHALL implement main and skid as two instances of one sub-module, pipe_reg_bank: a WIDTH-bit register with load enable, synchronous clear and asynchronous active-low reset.
REQ-029 SHALL allow a stage payload to be a concatenation of data, rd and control bits, so that a flushed entry carries zero control bits (no RegWrite) when ZERO_ON_FLUSH=1.

Verification (WIDTH=32)
REQ-030 SHALL verify reset: hold reset=0 for 3 cycles with in_valid=1, in_data=32'hDEAD_BEEF, then release -> out_valid=0 and count=0 during reset; in_ready=1 after the first edge; item accepted on the next edge; out_data=32'hDEAD_BEEF.
REQ-031 SHALL verify streaming: out_ready=1, feed 1..8 on consecutive cycles -> out_data shows 1..8 on consecutive cycles, each one cycle after acceptance, count steady at 1.
REQ-032 SHALL verify backpressure/skid: out_ready=0, send 8'hA1 then 8'hA2 -> count=2, in_ready=0, out_data=A1; then out_ready=1 -> A1, then A2, in order; count goes 2,1,0.
REQ-033 SHALL verify flush priority: in FULL, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0, offered item not delivered.
REQ-034 SHALL verify reset mid-operation: async reset=0 between edges while FULL -> out_valid=0 and count=0 immediately without a clock edge; nothing is emitted after release.
REQ-035 SHALL verify with a random scoreboard: random in_valid/out_ready/flush at 10% flush over 10k cycles -> no loss, duplication or reordering between flushes; in_ready never 1 when count=2.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage FSM encoding, default payload width and
// per-stage payload widths for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } stage_state_e;

    localparam int unsigned DefaultWidth = 32;

    // Control bits sit in the payload so a zeroed (flushed) entry never writes back.
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
    } mem_wb_t;

    localparam int unsigned IfIdWidth  = 64;
    localparam int unsigned IdExWidth  = 32 + 32 + 32 + 5 + 8;
    localparam int unsigned ExMemWidth = 32 + 32 + 5 + 4;
    localparam int unsigned MemWbWidth = $bits(mem_wb_t);

    function automatic logic [MemWbWidth-1:0] pack_mem_wb(input logic [31:0] data,
                                                           input logic [4:0]  rd,
                                                           input logic        reg_write,
                                                           input logic        mem_to_reg);
        mem_wb_t p;
        p.data       = data;
        p.rd         = rd;
        p.reg_write  = reg_write;
        p.mem_to_reg = mem_to_reg;
        return p;
    endfunction

endpackage

// File: rtl/pipe_reg_bank.sv
// WIDTH-bit register with load enable, synchronous clear (wins over load)
// and asynchronous active-low reset.
module pipe_reg_bank #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register; all handshake outputs come
// from registered state only.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned WIDTH         = DefaultWidth,
    parameter bit          ZERO_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    stage_state_e     state_q;
    logic             rdy_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_load;
    logic             skid_load;
    logic             bank_clear;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_ready  = rdy_q && (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = in_data;
        bank_clear = flush & ZERO_ON_FLUSH;
        if (!flush) begin
            unique case (state_q)
                StEmpty: main_load = in_fire;
                StBusy: begin
                    main_load = in_fire & out_fire;
                    skid_load = in_fire & ~out_fire;
                end
                StFull: begin
                    main_load = out_fire;
                    main_d    = skid_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count = 2'd0;
        unique case (state_q)
            StEmpty: count = 2'd0;
            StBusy:  count = 2'd1;
            StFull:  count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    // rdy_q keeps in_ready low through reset and the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (flush) begin
                state_q <= StEmpty;
            end else begin
                unique case (state_q)
                    StEmpty: if (in_fire) state_q <= StBusy;
                    StBusy: begin
                        if (in_fire && !out_fire) state_q <= StFull;
                        else if (!in_fire && out_fire) state_q <= StEmpty;
                    end
                    StFull: if (out_fire) state_q <= StBusy;
                    default: state_q <= StEmpty;
                endcase
            end
        end
    end

    pipe_reg_bank #(
        .WIDTH(WIDTH)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load_i (main_load),
        .clear_i(bank_clear),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_reg_bank #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_load),
        .clear_i(bank_clear),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random run, all checked
// against a queue-based model of a two-entry in-order buffer.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];
    logic [31:0] exp_main = '0;
    bit          m_rdy    = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH        (32),
        .ZERO_ON_FLUSH(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_main = '0;
        m_rdy    = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy && reset && mq.size() < 2));
        check({tag, ".out_data"}, out_data, exp_main);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag);
        bit          m_in_fire;
        bit          m_out_fire;
        logic [31:0] d;
        m_in_fire  = reset && in_valid && m_rdy && (mq.size() < 2);
        m_out_fire = reset && out_ready && (mq.size() > 0);
        d          = in_data;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (flush) begin
                mq.delete();
                exp_main = '0;
            end else begin
                if (m_out_fire) void'(mq.pop_front());
                if (m_in_fire) mq.push_back(d);
            end
            if (mq.size() > 0) exp_main = mq[0];
            m_rdy = 1'b1;
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        compare_all("rst_hold");
        for (int i = 0; i < 3; i++) step("rst_hold");

        reset = 1'b1;
        step("rst_rel1");
        step("rst_accept");
        check("rst_data", out_data, 32'hDEAD_BEEF);

        drive(1'b0, '0, 1'b1, 1'b0);
        step("drain");

        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b0);
            step("stream");
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step("stream_end");

        drive(1'b1, 32'hA1, 1'b0, 1'b0);
        step("skid_a1");
        drive(1'b1, 32'hA2, 1'b0, 1'b0);
        step("skid_a2");
        check("skid_full_cnt", 32'(count), 32'd2);
        check("skid_full_head", out_data, 32'hA1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            step("skid_drain");
        end

        drive(1'b1, 32'hB1, 1'b0, 1'b0);
        step("fl_b1");
        drive(1'b1, 32'hB2, 1'b0, 1'b0);
        step("fl_b2");
        drive(1'b1, 32'hC3, 1'b1, 1'b1);
        step("flush");
        check("flush_data", out_data, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            step("post_flush");
        end

        drive(1'b1, 32'hE1, 1'b0, 1'b0);
        step("mr_e1");
        drive(1'b1, 32'hE2, 1'b0, 1'b0);
        step("mr_e2");
        #2 reset = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        model_reset();
        drive(1'b0, '0, 1'b1, 1'b0);
        step("midrst_hold");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step("midrst_after");

        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0));
            step("rand");
            if (in_ready && count == 2'd2) check("rand_ready_full", 32'd1, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
